dvp_frame_writer: RTL and testbench
===================================

DVP_FRAME_WRITER -- requirements
Module: dvp_frame_writer

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 800: active pixels per line written to DDR.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 480: active lines per frame written to DDR.
REQ-003 SHALL have parameter SKIP_FRAMES, default 10: frames discarded after each enable before writing starts.
REQ-004 SHALL have parameter VSYNC_POL, default 1: active level of cam_vsync.
REQ-005 SHALL use one clock and a synchronous, active-high reset, exactly as follows:
- pixel_clock  in  1  single clock; camera PCLK domain.
- reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have the remaining ports:
- enable  in  1  camera init done; capture allowed when 1.
- cam_vsync  in  1  DVP vertical sync.
- cam_href  in  1  DVP line valid.
- cam_data  in  8  DVP byte; RGB565, high byte first.
- wr_load  out  1  one-cycle pulse; restarts the DDR write address.
- wfifo_wren  out  1  write strobe to the DDR write FIFO.
- wfifo_din  out  32  {8'h00, R8, G8, B8}.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame.
- xaddr  out  12  column of the current pixel, starting at 0.
- yaddr  out  12  row of the current pixel, starting at 0.
- err  out  2  sticky flags {short_frame, short_line}.

Function
REQ-007 SHALL register cam_vsync, cam_href and cam_data once before any use.
REQ-008 SHALL detect frame start on the registered vsync transition from active to inactive, as defined by VSYNC_POL.
REQ-009 SHALL implement the FSM:
- DISABLED -> SYNC when enable=1.
- SYNC -> SKIP on the first frame start.
- SKIP -> CAPTURE after SKIP_FRAMES further frame starts; with SKIP_FRAMES=0, SYNC -> CAPTURE directly.
- Any state -> DISABLED in the cycle after enable=0.
REQ-010 SHALL, in CAPTURE, pulse wr_load for one cycle at each frame start, two cycles after cam_vsync deasserts at the port, and clear xaddr, yaddr and the byte phase on that pulse.
REQ-011 SHALL toggle the byte phase on each registered href=1 cycle and clear it when href falls; an odd trailing byte is dropped.
REQ-012 SHALL expand RGB565 to RGB888 as follows: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
REQ-013 SHALL assert wfifo_wren with valid wfifo_din exactly 2 cycles after the second byte of a pixel is present at cam_data with cam_href=1, provided xaddr<IMAGE_WIDTH and yaddr<IMAGE_HEIGHT.
REQ-014 SHALL drop pixels beyond IMAGE_WIDTH in a line and lines beyond IMAGE_HEIGHT in a frame, with no strobe.
REQ-015 SHALL increment xaddr after each accepted pixel, and on href fall clear xaddr and increment yaddr (saturating at IMAGE_HEIGHT).
REQ-016 SHALL set err[0] when href falls with 0<xaddr<IMAGE_WIDTH.
REQ-017 SHALL set err[1] when a frame start occurs in CAPTURE with 0<yaddr<IMAGE_HEIGHT, which is a frame cut short.
REQ-018 SHALL pulse frame_done for one cycle, in the cycle after the wfifo_wren of pixel (IMAGE_WIDTH-1, IMAGE_HEIGHT-1); a short frame SHALL NOT produce frame_done.
REQ-019 SHALL keep wfifo_wren, wr_load and frame_done at 0 in DISABLED, SYNC and SKIP.
REQ-020 SHALL, when enable falls mid-frame, stop strobes in the cycle after enable=0; re-enabling SHALL restart from SYNC so that no partial frame is ever written.

Reset
REQ-021 SHALL, on reset, set the FSM to DISABLED and all outputs, counters, byte phase, input registers and err to 0.
REQ-022 SHALL let reset take priority over all other events, including a frame start in the same cycle.

Structure
REQ-023 SHALL place the FSM state encoding and the RGB565 field positions in the shared package isp_pkg.
REQ-024 SHALL implement the RGB565 to RGB888 conversion in one combinational sub-module, rgb565_unpack.

Verification
REQ-025 SHALL cover, with SKIP_FRAMES=0, WIDTH=4, HEIGHT=2 and bytes 0xF8,0x00 on every pixel: 8 strobes, each wfifo_din=0x00FF0000, then one frame_done pulse, err=0.
REQ-026 SHALL cover, with SKIP_FRAMES=2: the first 3 frames give no wr_load and no strobes; the 4th frame gives a wr_load and a full frame.
REQ-027 SHALL cover a 6-pixel line with WIDTH=4: exactly 4 strobes; a 3-pixel line gives 3 strobes and sets err[0]=1.
REQ-028 SHALL cover a vsync cut after line 0 of 2: no frame_done, err[1]=1, and the next frame gets wr_load with yaddr=0.
REQ-029 SHALL cover enable dropped mid-line: no strobe from the next cycle on; re-enable writes nothing until a frame start.
REQ-030 SHALL cover reset asserted mid-line: all outputs are 0 in the next cycle and the FSM is in DISABLED.

Source files
------------

// File: rtl/isp_pkg.sv
// Shared types for the camera capture path: FSM encoding and RGB565 field layout.
package isp_pkg;

   localparam int unsigned RGB565_W = 16;
   localparam int unsigned RGB888_W = 24;

   // RGB565 field positions (high byte arrives first on the DVP bus)
   localparam int unsigned R5_MSB = 15;
   localparam int unsigned R5_LSB = 11;
   localparam int unsigned G6_MSB = 10;
   localparam int unsigned G6_LSB = 5;
   localparam int unsigned B5_MSB = 4;
   localparam int unsigned B5_LSB = 0;

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_SYNC     = 2'd1,
      ST_SKIP     = 2'd2,
      ST_CAPTURE  = 2'd3
   } fsm_state_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb888_t;

endpackage

// File: rtl/rgb565_unpack.sv
// Combinational RGB565 -> RGB888 expansion by MSB replication.
module rgb565_unpack
   import isp_pkg::*;
(
   input  logic [RGB565_W-1:0] i_pix,
   output rgb888_t             o_rgb_c
);

   logic [4:0] w_r5;
   logic [5:0] w_g6;
   logic [4:0] w_b5;

   assign w_r5 = i_pix[R5_MSB:R5_LSB];
   assign w_g6 = i_pix[G6_MSB:G6_LSB];
   assign w_b5 = i_pix[B5_MSB:B5_LSB];

   // Replicate top bits into the low bits so full-scale stays full-scale
   assign o_rgb_c.r = {w_r5, w_r5[4:2]};
   assign o_rgb_c.g = {w_g6, w_g6[5:4]};
   assign o_rgb_c.b = {w_b5, w_b5[4:2]};

endmodule

// File: rtl/dvp_frame_writer.sv
// DVP camera capture: skips warm-up frames, then streams RGB888 words into the DDR write FIFO.
module dvp_frame_writer
   import isp_pkg::*;
#(
   parameter int unsigned IMAGE_WIDTH  = 800,
   parameter int unsigned IMAGE_HEIGHT = 480,
   parameter int unsigned SKIP_FRAMES  = 10,
   parameter bit          VSYNC_POL    = 1'b1
) (
   input  logic        pixel_clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        cam_vsync,
   input  logic        cam_href,
   input  logic [7:0]  cam_data,
   output logic        wr_load,
   output logic        wfifo_wren,
   output logic [31:0] wfifo_din,
   output logic        frame_done,
   output logic [11:0] xaddr,
   output logic [11:0] yaddr,
   output logic [1:0]  err
);

   localparam int unsigned AW      = 12;
   localparam int unsigned SKIP_CW = 16;

   localparam logic [AW-1:0]      X_END  = AW'(IMAGE_WIDTH);
   localparam logic [AW-1:0]      Y_END  = AW'(IMAGE_HEIGHT);
   localparam logic [AW-1:0]      X_LAST = AW'(IMAGE_WIDTH - 1);
   localparam logic [AW-1:0]      Y_LAST = AW'(IMAGE_HEIGHT - 1);
   localparam logic [SKIP_CW-1:0] SKIP_N = SKIP_CW'(SKIP_FRAMES);

   fsm_state_t         r_state;
   logic               r_vsync;
   logic               r_vsync_d;
   logic               r_href;
   logic               r_href_d;
   logic [7:0]         r_data;
   logic [7:0]         r_hi;
   logic               r_phase;
   logic               r_last;
   logic [SKIP_CW-1:0] r_skip_cnt;

   logic               w_frame_start;
   logic               w_href_fall;
   logic               w_pix_second;
   logic               w_in_window;
   logic [15:0]        w_pix;
   rgb888_t            w_rgb;

   assign w_frame_start = (r_vsync_d == VSYNC_POL) && (r_vsync != VSYNC_POL);
   assign w_href_fall   = r_href_d && !r_href;
   assign w_pix_second  = r_href && r_phase;
   assign w_in_window   = (xaddr < X_END) && (yaddr < Y_END);
   assign w_pix         = {r_hi, r_data};

   rgb565_unpack u_unpack (
      .i_pix   (w_pix),
      .o_rgb_c (w_rgb)
   );

   // Input capture stage plus one-cycle history for edge detection
   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         r_vsync   <= 1'b0;
         r_vsync_d <= 1'b0;
         r_href    <= 1'b0;
         r_href_d  <= 1'b0;
         r_data    <= 8'h00;
      end else begin
         r_vsync   <= cam_vsync;
         r_vsync_d <= r_vsync;
         r_href    <= cam_href;
         r_href_d  <= r_href;
         r_data    <= cam_data;
      end
   end

   // Capture FSM, pixel assembly, address counters and registered outputs
   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         r_state    <= ST_DISABLED;
         r_hi       <= 8'h00;
         r_phase    <= 1'b0;
         r_last     <= 1'b0;
         r_skip_cnt <= '0;
         wr_load    <= 1'b0;
         wfifo_wren <= 1'b0;
         wfifo_din  <= 32'h0;
         frame_done <= 1'b0;
         xaddr      <= '0;
         yaddr      <= '0;
         err        <= 2'b00;
      end else begin
         wr_load    <= 1'b0;
         wfifo_wren <= 1'b0;
         frame_done <= r_last;
         r_last     <= 1'b0;
         r_phase    <= r_href ? ~r_phase : 1'b0;
         if (r_href && !r_phase) begin
            r_hi <= r_data;
         end

         if (!enable) begin
            r_state    <= ST_DISABLED;
            r_skip_cnt <= '0;
            r_phase    <= 1'b0;
            frame_done <= 1'b0;
            xaddr      <= '0;
            yaddr      <= '0;
         end else begin
            case (r_state)
               ST_DISABLED: r_state <= ST_SYNC;

               ST_SYNC: begin
                  if (w_frame_start) begin
                     r_skip_cnt <= '0;
                     if (SKIP_FRAMES == 0) begin
                        // Frame already in flight is partial: park y past the window until next start
                        r_state <= ST_CAPTURE;
                        yaddr   <= Y_END;
                     end else begin
                        r_state <= ST_SKIP;
                     end
                  end
               end

               ST_SKIP: begin
                  if (w_frame_start) begin
                     if (r_skip_cnt + SKIP_CW'(1) == SKIP_N) begin
                        r_state <= ST_CAPTURE;
                        yaddr   <= Y_END;
                     end else begin
                        r_skip_cnt <= r_skip_cnt + SKIP_CW'(1);
                     end
                  end
               end

               ST_CAPTURE: begin
                  if (w_frame_start) begin
                     wr_load <= 1'b1;
                     xaddr   <= '0;
                     yaddr   <= '0;
                     r_phase <= 1'b0;
                     if (yaddr != '0 && yaddr < Y_END) begin
                        err[1] <= 1'b1;
                     end
                  end else begin
                     if (w_pix_second && w_in_window) begin
                        wfifo_wren <= 1'b1;
                        wfifo_din  <= {8'h00, w_rgb};
                        xaddr      <= xaddr + AW'(1);
                        r_last     <= (xaddr == X_LAST) && (yaddr == Y_LAST);
                     end
                     if (w_href_fall) begin
                        if (xaddr != '0 && xaddr < X_END) begin
                           err[0] <= 1'b1;
                        end
                        xaddr <= '0;
                        if (yaddr < Y_END) begin
                           yaddr <= yaddr + AW'(1);
                        end
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dvp_frame_writer.sv
// Directed bench for dvp_frame_writer (WIDTH=4, HEIGHT=2; SKIP_FRAMES 0 and 2 instances).
module tb_dvp_frame_writer;
   import isp_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        vs;
   logic        hr;
   logic [7:0]  d;

   logic        a_load, a_wren, a_done;
   logic [31:0] a_din;
   logic [11:0] a_x, a_y;
   logic [1:0]  a_err;

   logic        b_load, b_wren, b_done;
   logic [31:0] b_din;
   logic [11:0] b_x, b_y;
   logic [1:0]  b_err;

   logic [15:0] t_pix;
   rgb888_t     t_rgb;

   int n_pass  = 0;
   int n_total = 0;

   int wren_a = 0, load_a = 0, done_a = 0;
   int wren_b = 0, load_b = 0, done_b = 0, bad_din_b = 0;
   logic [31:0] last_din_a = 32'h0;

   always #5 clk = ~clk;

   dvp_frame_writer #(
      .IMAGE_WIDTH (4), .IMAGE_HEIGHT (2), .SKIP_FRAMES (0), .VSYNC_POL (1'b1)
   ) dut (
      .pixel_clock (clk), .reset (rst), .enable (en),
      .cam_vsync (vs), .cam_href (hr), .cam_data (d),
      .wr_load (a_load), .wfifo_wren (a_wren), .wfifo_din (a_din),
      .frame_done (a_done), .xaddr (a_x), .yaddr (a_y), .err (a_err)
   );

   dvp_frame_writer #(
      .IMAGE_WIDTH (4), .IMAGE_HEIGHT (2), .SKIP_FRAMES (2), .VSYNC_POL (1'b1)
   ) dut_s (
      .pixel_clock (clk), .reset (rst), .enable (en),
      .cam_vsync (vs), .cam_href (hr), .cam_data (d),
      .wr_load (b_load), .wfifo_wren (b_wren), .wfifo_din (b_din),
      .frame_done (b_done), .xaddr (b_x), .yaddr (b_y), .err (b_err)
   );

   rgb565_unpack u_unp (.i_pix (t_pix), .o_rgb_c (t_rgb));

   // Event counters sampled mid-cycle
   always @(negedge clk) begin
      if (a_wren) begin wren_a++; last_din_a = a_din; end
      if (a_load) load_a++;
      if (a_done) done_a++;
      if (b_wren) begin
         wren_b++;
         if (b_din !== 32'h00FF0000) bad_din_b++;
      end
      if (b_load) load_b++;
      if (b_done) done_b++;
   end

   typedef struct {
      logic        vs;
      logic        hr;
      logic [7:0]  d;
      logic [2:0]  ctl;     // {wren, load, done} expected after this cycle's edge
      logic        chk_xy;
      logic [11:0] x;
      logic [11:0] y;
   } vec_t;

   typedef struct {
      logic [15:0] pix;
      logic [23:0] rgb;
   } uvec_t;

   vec_t  tbl[25];
   uvec_t utbl[7];

   function automatic vec_t mk(logic v, logic h, logic [7:0] dd, logic [2:0] c,
                               logic k, int x, int y);
      vec_t r;
      r.vs = v; r.hr = h; r.d = dd; r.ctl = c; r.chk_xy = k;
      r.x = 12'(x); r.y = 12'(y);
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic cyc(input logic v, input logic h, input logic [7:0] dd);
      vs = v; hr = h; d = dd;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
   endtask

   task automatic vsync_start();
      cyc(1'b1, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 8'h00);
      idle(3);
   endtask

   task automatic line(input int np, input logic [7:0] hi, input logic [7:0] lo);
      for (int p = 0; p < np; p++) begin
         cyc(1'b0, 1'b1, hi);
         cyc(1'b0, 1'b1, lo);
      end
      idle(3);
   endtask

   task automatic frame(input int nl, input int np, input logic [7:0] hi, input logic [7:0] lo);
      vsync_start();
      for (int l = 0; l < nl; l++) line(np, hi, lo);
      idle(2);
   endtask

   initial begin
      int s_wren, s_done, s_load;
      logic seen;
      logic any_wren;

      tbl[0]  = mk(1, 0, 8'h00, 3'b000, 0, 0, 0);
      tbl[1]  = mk(1, 0, 8'h00, 3'b000, 0, 0, 0);
      tbl[2]  = mk(0, 0, 8'h00, 3'b000, 0, 0, 0);
      tbl[3]  = mk(0, 0, 8'h00, 3'b010, 1, 0, 0);
      tbl[4]  = mk(0, 1, 8'hF8, 3'b000, 1, 0, 0);
      tbl[5]  = mk(0, 1, 8'h00, 3'b000, 1, 0, 0);
      tbl[6]  = mk(0, 1, 8'hF8, 3'b100, 1, 1, 0);
      tbl[7]  = mk(0, 1, 8'h00, 3'b000, 1, 1, 0);
      tbl[8]  = mk(0, 1, 8'hF8, 3'b100, 1, 2, 0);
      tbl[9]  = mk(0, 1, 8'h00, 3'b000, 1, 2, 0);
      tbl[10] = mk(0, 1, 8'hF8, 3'b100, 1, 3, 0);
      tbl[11] = mk(0, 1, 8'h00, 3'b000, 1, 3, 0);
      tbl[12] = mk(0, 0, 8'h00, 3'b100, 1, 4, 0);
      tbl[13] = mk(0, 0, 8'h00, 3'b000, 1, 0, 1);
      tbl[14] = mk(0, 1, 8'hF8, 3'b000, 1, 0, 1);
      tbl[15] = mk(0, 1, 8'h00, 3'b000, 1, 0, 1);
      tbl[16] = mk(0, 1, 8'hF8, 3'b100, 1, 1, 1);
      tbl[17] = mk(0, 1, 8'h00, 3'b000, 1, 1, 1);
      tbl[18] = mk(0, 1, 8'hF8, 3'b100, 1, 2, 1);
      tbl[19] = mk(0, 1, 8'h00, 3'b000, 1, 2, 1);
      tbl[20] = mk(0, 1, 8'hF8, 3'b100, 1, 3, 1);
      tbl[21] = mk(0, 1, 8'h00, 3'b000, 1, 3, 1);
      tbl[22] = mk(0, 0, 8'h00, 3'b100, 1, 4, 1);
      tbl[23] = mk(0, 0, 8'h00, 3'b001, 1, 0, 2);
      tbl[24] = mk(0, 0, 8'h00, 3'b000, 1, 0, 2);

      utbl[0] = '{16'hF800, 24'hFF0000};
      utbl[1] = '{16'h1234, 24'h1045A5};
      utbl[2] = '{16'hFFFF, 24'hFFFFFF};
      utbl[3] = '{16'h07E0, 24'h00FF00};
      utbl[4] = '{16'h001F, 24'h0000FF};
      utbl[5] = '{16'h0000, 24'h000000};
      utbl[6] = '{16'h8410, 24'h848284};

      // Reset state
      rst = 1'b1; en = 1'b0; vs = 1'b0; hr = 1'b0; d = 8'h00; t_pix = 16'h0;
      idle(3);
      check("reset_ctl", 32'({a_wren, a_load, a_done}), 32'h0);
      check("reset_din", a_din, 32'h0);
      check("reset_xy", {8'h0, a_x, a_y}, 32'h0);
      check("reset_err", 32'(a_err), 32'h0);
      check("reset_state", 32'(dut.r_state), 32'(ST_DISABLED));

      // Colour expansion
      for (int i = 0; i < 7; i++) begin
         t_pix = utbl[i].pix;
         #1;
         check($sformatf("unpack_%04h", utbl[i].pix), 32'(t_rgb), 32'(utbl[i].rgb));
      end

      rst = 1'b0;
      idle(2);
      en = 1'b1;
      idle(4);

      // Frame 1: SYNC consumes the first frame start; partial frame is never written
      frame(2, 4, 8'hF8, 8'h00);
      check("f1_wren_a", 32'(wren_a), 32'd0);
      check("f1_load_a", 32'(load_a), 32'd0);

      // Frame 2: cycle-accurate full frame on the SKIP_FRAMES=0 instance
      s_wren = wren_a; s_done = done_a;
      for (int i = 0; i < 25; i++) begin
         cyc(tbl[i].vs, tbl[i].hr, tbl[i].d);
         check($sformatf("tbl%0d_ctl", i), 32'({a_wren, a_load, a_done}), 32'(tbl[i].ctl));
         if (tbl[i].chk_xy)
            check($sformatf("tbl%0d_xy", i), {8'h0, a_x, a_y}, {8'h0, tbl[i].x, tbl[i].y});
         if (tbl[i].ctl[2])
            check($sformatf("tbl%0d_din", i), a_din, 32'h00FF0000);
      end
      idle(3);
      check("f2_wren_total", 32'(wren_a - s_wren), 32'd8);
      check("f2_done_total", 32'(done_a - s_done), 32'd1);
      check("f2_err", 32'(a_err), 32'h0);
      check("skip_f2_load", 32'(load_b), 32'd0);
      check("skip_f2_wren", 32'(wren_b), 32'd0);

      // Frames 3 and 4 on the SKIP_FRAMES=2 instance
      frame(2, 4, 8'hF8, 8'h00);
      check("skip_f3_load", 32'(load_b), 32'd0);
      check("skip_f3_wren", 32'(wren_b), 32'd0);
      frame(2, 4, 8'hF8, 8'h00);
      check("skip_f4_load", 32'(load_b), 32'd1);
      check("skip_f4_wren", 32'(wren_b), 32'd8);
      check("skip_f4_done", 32'(done_b), 32'd1);
      check("skip_f4_din", 32'(bad_din_b), 32'd0);
      check("skip_f4_err", 32'(b_err), 32'h0);

      // Long line clipped to width, then a short line
      s_wren = wren_a; s_done = done_a;
      vsync_start();
      line(6, 8'h12, 8'h34);
      check("long_line_wren", 32'(wren_a - s_wren), 32'd4);
      check("long_line_err", 32'(a_err), 32'h0);
      check("long_line_din", last_din_a, 32'h001045A5);
      line(3, 8'h07, 8'hE0);
      check("short_line_wren", 32'(wren_a - s_wren), 32'd7);
      check("short_line_err", 32'(a_err), 32'h1);
      check("short_line_din", last_din_a, 32'h0000FF00);
      idle(2);
      check("short_line_done", 32'(done_a - s_done), 32'd0);

      // Frame cut after line 0: new frame start restarts addressing
      s_done = done_a;
      vsync_start();
      line(4, 8'hF8, 8'h00);
      check("cut_y_before", 32'(a_y), 32'd1);
      cyc(1'b1, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 8'h00);
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         cyc(1'b0, 1'b0, 8'h00);
         if (a_load) begin
            seen = 1'b1;
            check("cut_load_xy", {8'h0, a_x, a_y}, 32'h0);
         end
      end
      check("cut_load_seen", 32'(seen), 32'd1);
      check("cut_err", 32'(a_err), 32'h3);
      check("cut_no_done", 32'(done_a - s_done), 32'd0);
      s_wren = wren_a;
      line(4, 8'hF8, 8'h00);
      line(4, 8'hF8, 8'h00);
      idle(2);
      check("after_cut_wren", 32'(wren_a - s_wren), 32'd8);
      check("after_cut_done", 32'(done_a - s_done), 32'd1);

      // Enable dropped mid-line
      vsync_start();
      s_wren = wren_a;
      cyc(1'b0, 1'b1, 8'hF8);
      cyc(1'b0, 1'b1, 8'h00);
      cyc(1'b0, 1'b1, 8'hF8);
      cyc(1'b0, 1'b1, 8'h00);
      en = 1'b0;
      any_wren = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, 1'b1, (i % 2 == 0) ? 8'hF8 : 8'h00);
         any_wren = any_wren | a_wren;
      end
      check("en_drop_no_wren", 32'(any_wren), 32'd0);
      check("en_drop_count", 32'(wren_a - s_wren), 32'd1);
      check("en_drop_state", 32'(dut.r_state), 32'(ST_DISABLED));
      // Re-enable mid-line: nothing is written before a frame start
      s_wren = wren_a; s_load = load_a;
      en = 1'b1;
      for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, (i % 2 == 0) ? 8'hF8 : 8'h00);
      idle(3);
      line(4, 8'hF8, 8'h00);
      check("reen_no_wren", 32'(wren_a - s_wren), 32'd0);
      check("reen_no_load", 32'(load_a - s_load), 32'd0);

      // Reset mid-line while capturing
      frame(2, 4, 8'hF8, 8'h00);
      vsync_start();
      for (int p = 0; p < 3; p++) begin
         cyc(1'b0, 1'b1, 8'h07);
         cyc(1'b0, 1'b1, 8'hE0);
      end
      cyc(1'b0, 1'b1, 8'h07);
      cyc(1'b0, 1'b1, 8'hE0);
      check("pre_reset_x", 32'(a_x), 32'd3);
      rst = 1'b1;
      cyc(1'b0, 1'b1, 8'h07);
      check("rst_mid_ctl", 32'({a_wren, a_load, a_done}), 32'h0);
      check("rst_mid_din", a_din, 32'h0);
      check("rst_mid_xy", {8'h0, a_x, a_y}, 32'h0);
      check("rst_mid_err", 32'(a_err), 32'h0);
      check("rst_mid_state", 32'(dut.r_state), 32'(ST_DISABLED));
      rst = 1'b0;
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
